dice_roller: RTL and testbench

- Sits directly downstream of the 8-bit LFSR random source in the craps datapath.
- On a roll request, it steps the LFSR through its clock-enable and samples the LFSR output each cycle.
- It uses rejection sampling on 3-bit fields to produce two unbiased dice values (1..6), plus their sum and a doubles flag.
- It hands the result to the game-control FSM with a one-cycle done pulse.

---
 rtl/craps_pkg.sv | 23 ++
 rtl/die_field_filter.sv | 17 +
 rtl/dice_roller.sv | 100 ++++++++++
 tb/tb_dice_roller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/craps_pkg.sv
// Shared types and constants for the craps datapath.
package craps_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW1 = 2'd1,
    DRAW2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DIE_W = 3;
  localparam int unsigned SUM_W = 4;
  localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

  // (c mod 6) + 1, used when the draw budget runs out
  function automatic logic [DIE_W-1:0] fallback_map(input logic [DIE_W-1:0] c);
    logic [DIE_W-1:0] m;
    m = (c < 3'd6) ? (c + DIE_W'(1)) : (c - DIE_W'(5));
    return m;
  endfunction

endpackage

// File: rtl/die_field_filter.sv
// Rejection filter for one 3-bit random field: accept 1..6, or force a mapped value on the last try.
module die_field_filter
  import craps_pkg::*;
(
  input  logic [DIE_W-1:0] field,
  input  logic             last_try,
  output logic             accept_c,
  output logic [DIE_W-1:0] die_c
);

  logic in_range;

  assign in_range = (field >= DIE_MIN) && (field <= DIE_MAX);
  assign accept_c = in_range || last_try;
  assign die_c    = in_range ? field : fallback_map(field);

endmodule

// File: rtl/dice_roller.sv
// Draws two unbiased dice from the LFSR by rejection sampling and reports them with a done pulse.
module dice_roller
  import craps_pkg::*;
#(
  parameter int unsigned RND_W     = 8,
  parameter int unsigned MAX_DRAWS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll,
  input  logic [RND_W-1:0] rnd,
  output logic             lfsr_en,
  output logic             busy,
  output logic             done,
  output logic [DIE_W-1:0] die1,
  output logic [DIE_W-1:0] die2,
  output logic [SUM_W-1:0] sum,
  output logic             is_double
);

  localparam int unsigned TRY_W = (MAX_DRAWS > 1) ? $clog2(MAX_DRAWS) : 1;

  state_t           state;
  logic [TRY_W-1:0] try_cnt;
  logic [DIE_W-1:0] die1_r;
  logic             last_try;
  logic             f1_take;
  logic             f2_take;
  logic [DIE_W-1:0] f1_die;
  logic [DIE_W-1:0] f2_die;
  logic             unused_rnd;

  assign unused_rnd = ^rnd[RND_W-1:6];
  assign last_try   = (try_cnt == TRY_W'(MAX_DRAWS - 1));
  assign lfsr_en    = (state == DRAW1) || (state == DRAW2);
  assign busy       = (state != IDLE);

  die_field_filter u_filt1 (
    .field    (rnd[2:0]),
    .last_try (last_try),
    .accept_c (f1_take),
    .die_c    (f1_die)
  );

  die_field_filter u_filt2 (
    .field    (rnd[5:3]),
    .last_try (last_try),
    .accept_c (f2_take),
    .die_c    (f2_die)
  );

  // Roll sequencer; published results only move on the DRAW2 exit edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      try_cnt   <= '0;
      die1_r    <= '0;
      die1      <= '0;
      die2      <= '0;
      sum       <= '0;
      is_double <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (roll) begin
            state   <= DRAW1;
            try_cnt <= '0;
          end
        end
        DRAW1: begin
          if (f1_take) begin
            die1_r  <= f1_die;
            try_cnt <= '0;
            state   <= DRAW2;
          end else begin
            try_cnt <= try_cnt + TRY_W'(1);
          end
        end
        DRAW2: begin
          if (f2_take) begin
            die1      <= die1_r;
            die2      <= f2_die;
            sum       <= SUM_W'(die1_r) + SUM_W'(f2_die);
            is_double <= (die1_r == f2_die);
            done      <= 1'b1;
            try_cnt   <= '0;
            state     <= DONE;
          end else begin
            try_cnt <= try_cnt + TRY_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: latency, rejection, fallback, busy handling, reset abort and LFSR soak.
module tb_dice_roller;

  logic       clock;
  logic       reset;
  logic       roll_a;
  logic       roll_b;
  logic [7:0] rnd_dir;
  logic [7:0] lfsr;
  logic       soak;
  logic       lfsr_load;
  logic [7:0] rnd;

  logic       lfsr_en_a, busy_a, done_a, dbl_a;
  logic [2:0] die1_a, die2_a;
  logic [3:0] sum_a;
  logic       lfsr_en_b, busy_b, done_b, dbl_b;
  logic [2:0] die1_b, die2_b;
  logic [3:0] sum_b;

  int vectors;
  int miscompares;

  assign rnd = soak ? lfsr : rnd_dir;

  dice_roller dut (
    .clock(clock), .reset(reset), .roll(roll_a), .rnd(rnd),
    .lfsr_en(lfsr_en_a), .busy(busy_a), .done(done_a),
    .die1(die1_a), .die2(die2_a), .sum(sum_a), .is_double(dbl_a)
  );

  dice_roller #(.MAX_DRAWS(4)) dut4 (
    .clock(clock), .reset(reset), .roll(roll_b), .rnd(rnd),
    .lfsr_en(lfsr_en_b), .busy(busy_b), .done(done_b),
    .die1(die1_b), .die2(die2_b), .sum(sum_b), .is_double(dbl_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Byte-per-enable LFSR (x^8+x^6+x^5+x^4+1, eight shifts per step) so each sample is a fresh byte
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    for (int k = 0; k < 8; k++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    return r;
  endfunction

  always @(posedge clock) begin
    if (lfsr_load) lfsr <= 8'h5A;
    else if (soak && lfsr_en_a) lfsr <= lfsr_step(lfsr);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle roll and stop in the cycle where done is high
  task automatic roll_and_wait(input bit use4, input int limit, input string tag,
                               output int lat, output int en_cnt);
    logic d;
    if (use4) roll_b = 1'b1; else roll_a = 1'b1;
    tick;
    roll_a = 1'b0;
    roll_b = 1'b0;
    lat    = 1;
    en_cnt = 0;
    d      = use4 ? done_b : done_a;
    while (!d && lat < limit) begin
      if (use4 ? lfsr_en_b : lfsr_en_a) en_cnt++;
      tick;
      lat++;
      d = use4 ? done_b : done_a;
    end
    chk({tag, "_done_seen"}, 32'(d), 32'd1);
  endtask

  int lat, en_cnt, n_done, n_chg, first_done, last_done;
  int face_cnt [1:6];
  logic [10:0] prev_out;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    roll_a      = 1'b0;
    roll_b      = 1'b0;
    rnd_dir     = 8'h00;
    soak        = 1'b0;
    lfsr_load   = 1'b0;
    for (int f = 1; f <= 6; f++) face_cnt[f] = 0;
    tick;
    tick;
    chk("rst_die1", 32'(die1_a), 32'd0);
    chk("rst_sum", 32'(sum_a), 32'd0);
    chk("rst_busy_en_done", {29'd0, busy_a, lfsr_en_a, done_a}, 32'd0);
    reset = 1'b0;
    tick;

    // Basic roll: fields 2 and 3 accepted immediately
    rnd_dir = 8'b00_011_010;
    roll_a  = 1'b1;
    tick;
    roll_a = 1'b0;
    chk("basic_en_t1", 32'(lfsr_en_a), 32'd1);
    chk("basic_busy_t1", 32'(busy_a), 32'd1);
    tick;
    chk("basic_en_t2", 32'(lfsr_en_a), 32'd1);
    chk("basic_nodone_t2", 32'(done_a), 32'd0);
    tick;
    chk("basic_done_t3", 32'(done_a), 32'd1);
    chk("basic_en_t3", 32'(lfsr_en_a), 32'd0);
    chk("basic_dice", {24'd0, die1_a, die2_a, sum_a}, {24'd0, 3'd2, 3'd3, 4'd5});
    chk("basic_dbl", 32'(dbl_a), 32'd0);
    tick;
    chk("basic_busy_t4", {30'd0, busy_a, done_a}, 32'd0);

    // Rejection: die1 field 0, 7, then 5; die2 field 5
    rnd_dir = {2'b00, 3'd5, 3'd0};
    roll_a  = 1'b1;
    tick;
    roll_a  = 1'b0;
    en_cnt  = 32'(lfsr_en_a);
    tick;
    rnd_dir = {2'b00, 3'd5, 3'd7};
    en_cnt += 32'(lfsr_en_a);
    tick;
    rnd_dir = {2'b00, 3'd5, 3'd5};
    en_cnt += 32'(lfsr_en_a);
    chk("rej_no_early_done", 32'(done_a), 32'd0);
    tick;
    en_cnt += 32'(lfsr_en_a);
    tick;
    chk("rej_done_t5", 32'(done_a), 32'd1);
    chk("rej_en_count", 32'(en_cnt), 32'd4);
    chk("rej_dice", {24'd0, die1_a, die2_a, sum_a}, {24'd0, 3'd5, 3'd5, 4'd10});
    chk("rej_dbl", 32'(dbl_a), 32'd1);
    tick;

    // Fallback with MAX_DRAWS=4: 7 maps to 2 on both dice
    rnd_dir = 8'hFF;
    roll_and_wait(1'b1, 20, "fb", lat, en_cnt);
    chk("fb_latency", 32'(lat), 32'd9);
    chk("fb_en_count", 32'(en_cnt), 32'd8);
    chk("fb_dice", {24'd0, die1_b, die2_b, sum_b}, {24'd0, 3'd2, 3'd2, 4'd4});
    chk("fb_dbl", 32'(dbl_b), 32'd1);
    tick;

    // roll pulses in DRAW1 and DONE are ignored
    rnd_dir  = {2'b00, 3'd3, 3'd4};
    prev_out = {die1_a, die2_a, sum_a, dbl_a};
    n_done   = 0;
    n_chg    = 0;
    roll_a   = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      roll_a = (c == 1) || (c == 3);
      if (done_a) n_done++;
      if ({die1_a, die2_a, sum_a, dbl_a} != prev_out) n_chg++;
      prev_out = {die1_a, die2_a, sum_a, dbl_a};
    end
    roll_a = 1'b0;
    chk("busy_one_done", 32'(n_done), 32'd1);
    chk("busy_one_change", 32'(n_chg), 32'd1);
    chk("busy_dice", {24'd0, die1_a, die2_a, sum_a}, {24'd0, 3'd4, 3'd3, 4'd7});
    chk("busy_idle_after", 32'(busy_a), 32'd0);

    // roll held for 20 cycles: done every 4 cycles
    rnd_dir    = {2'b00, 3'd1, 3'd6};
    roll_a     = 1'b1;
    n_done     = 0;
    first_done = 0;
    last_done  = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (done_a) begin
        n_done++;
        if (first_done == 0) first_done = c;
        last_done = c;
      end
    end
    roll_a = 1'b0;
    chk("cont_done_count", 32'(n_done), 32'd5);
    chk("cont_first_done", 32'(first_done), 32'd3);
    chk("cont_last_done", 32'(last_done), 32'd19);
    chk("cont_dice", {24'd0, die1_a, die2_a, sum_a}, {24'd0, 3'd6, 3'd1, 4'd7});
    tick;
    tick;

    // Reset during DRAW2 clears everything without waiting for an edge
    rnd_dir = {2'b00, 3'd3, 3'd2};
    roll_a  = 1'b1;
    tick;
    roll_a = 1'b0;
    tick;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {18'd0, die1_a, die2_a, sum_a, dbl_a}, 32'd0);
    chk("rst_mid_ctl", {29'd0, busy_a, lfsr_en_a, done_a}, 32'd0);
    tick;
    reset  = 1'b0;
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (done_a) n_done++;
    end
    chk("rst_mid_no_done", 32'(n_done), 32'd0);
    roll_and_wait(1'b0, 40, "post_rst", lat, en_cnt);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_dice", {24'd0, die1_a, die2_a, sum_a}, {24'd0, 3'd2, 3'd3, 4'd5});
    tick;

    // Soak against the LFSR seeded 8'h5A
    lfsr_load = 1'b1;
    tick;
    lfsr_load = 1'b0;
    soak      = 1'b1;
    for (int r = 0; r < 1000; r++) begin
      roll_and_wait(1'b0, 40, "soak", lat, en_cnt);
      chk("soak_range", 32'((die1_a >= 3'd1) && (die1_a <= 3'd6) &&
                            (die2_a >= 3'd1) && (die2_a <= 3'd6)), 32'd1);
      chk("soak_sum", 32'(sum_a), 32'(die1_a) + 32'(die2_a));
      chk("soak_dbl", 32'(dbl_a), 32'(die1_a == die2_a));
      if (die1_a >= 3'd1 && die1_a <= 3'd6) face_cnt[die1_a]++;
      if (die2_a >= 3'd1 && die2_a <= 3'd6) face_cnt[die2_a]++;
      tick;
    end
    soak = 1'b0;
    // 2000 dice in total: each face within +/-20% of 333
    for (int f = 1; f <= 6; f++)
      chk($sformatf("soak_face%0d", f), 32'(face_cnt[f] >= 267 && face_cnt[f] <= 400), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
